// File: rtl/clk_tick_gen.sv
// Multi-channel programmable tick / square-wave divider on mclk with deferred or immediate divisor updates.
// Optional macro CLK_TICK_GEN_ONESHOT_EN adds a per-channel one-shot input.
module clk_tick_gen #(
    parameter int NCH     = 4,
    parameter int W       = 28,
    parameter int RST_DIV = 262144,
    localparam int CW     = $clog2(NCH)
) (
    input  logic           mclk,
    input  logic           clr,
    input  logic           wr_en,
    input  logic [CW-1:0]  wr_ch,
    input  logic [W-1:0]   wr_div,
    input  logic           wr_now,
    input  logic           sync,
`ifdef CLK_TICK_GEN_ONESHOT_EN
    input  logic [NCH-1:0] oneshot,
`endif
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] pending
);

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [W-1:0] cnt;
        logic [W-1:0] div;
        logic [W-1:0] sdiv;
        logic         pend_r;
        logic         tick_r;
        logic         clk_r;
        logic         hit;
        logic         terminal;
        logic         stop_after;

        // Out-of-range channel numbers never match, so such writes are dropped.
        assign hit      = wr_en && (int'(wr_ch) == ch);
        assign terminal = (div != '0) && (cnt == div - W'(1));

`ifdef CLK_TICK_GEN_ONESHOT_EN
        assign stop_after = oneshot[ch];
`else
        assign stop_after = 1'b0;
`endif

        always_ff @(posedge mclk or negedge clr) begin
            if (!clr) begin
                cnt    <= '0;
                div    <= W'(RST_DIV);
                sdiv   <= '0;
                pend_r <= 1'b0;
                tick_r <= 1'b0;
                clk_r  <= 1'b0;
            end else if (sync) begin
                // Realign: a write in the same cycle wins over any pending value.
                cnt    <= '0;
                tick_r <= 1'b0;
                clk_r  <= 1'b0;
                pend_r <= 1'b0;
                if (hit)
                    div <= wr_div;
                else if (pend_r)
                    div <= sdiv;
            end else if (hit && wr_now) begin
                div    <= wr_div;
                cnt    <= '0;
                pend_r <= 1'b0;
                tick_r <= 1'b0;
            end else if (div == '0) begin
                cnt    <= '0;
                tick_r <= 1'b0;
                if (hit) begin
                    div    <= wr_div;
                    pend_r <= 1'b0;
                end
            end else begin
                tick_r <= terminal;
                if (terminal) begin
                    cnt    <= '0;
                    clk_r  <= ~clk_r;
                    if (pend_r)
                        div <= sdiv;
                    else if (stop_after)
                        div <= '0;
                end else begin
                    cnt <= cnt + W'(1);
                end
                // A deferred write landing on the terminal edge stays pending for the next period.
                if (hit) begin
                    sdiv   <= wr_div;
                    pend_r <= 1'b1;
                end else if (terminal) begin
                    pend_r <= 1'b0;
                end
            end
        end

        assign tick[ch]    = tick_r;
        assign clk_out[ch] = clk_r;
        assign pending[ch] = pend_r;
    end

endmodule
